// File: rtl/seg_rotate_anim.sv
// ---------------------------------------------------------------------------
// seg_rotate_anim
//
// Self-timed rotating-box animation for an N-digit 7-segment display. A "top
// box" glyph sweeps left to right across the digits, then a "bottom box"
// glyph sweeps back right to left, so the lit segment appears to run around
// the display. The block owns its step prescaler and position counter.
//
// Optional feature macro: SEG_ROT_SPEED_EN
//   defined   : adds the 'speed' port; the step period becomes PRESCALE >> speed
//               (never shorter than one cycle), and a change of speed restarts
//               the prescaler from 0.
//   undefined : no 'speed' port; the step period is fixed at PRESCALE.
//
// Ports
//   clk             in   1           system clock
//   rst_n           in   1           asynchronous reset, active low
//   run             in   1           1 = advance on step ticks, 0 = freeze
//   dir             in   1           0 = forward loop, 1 = reverse loop
//   clear           in   1           synchronous: position 0, prescaler 0
//   speed           in   2           step-rate select (SEG_ROT_SPEED_EN only)
//   data            out  8           segment pattern, registered
//   display_enable  out  NUM_DIGITS  active-low digit enables, one-cold
//   wrap            out  1           one-cycle pulse when the position wraps
// ---------------------------------------------------------------------------
module seg_rotate_anim #(
  parameter int unsigned NUM_DIGITS = 4,
  parameter int unsigned PRESCALE   = 25_000_000,
  parameter int unsigned CNT_W      = 25,
  parameter logic [7:0]  TOP_PAT    = 8'b00111001,
  parameter logic [7:0]  BOT_PAT    = 8'b11000101
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  run,
  input  logic                  dir,
  input  logic                  clear,
`ifdef SEG_ROT_SPEED_EN
  input  logic [1:0]            speed,
`endif
  output logic [7:0]            data,
  output logic [NUM_DIGITS-1:0] display_enable,
  output logic                  wrap
);

  // The loop visits every digit twice: once along the top, once along the
  // bottom.
  localparam int unsigned NumPos = 2 * NUM_DIGITS;
  localparam int unsigned PosW   = (NumPos > 1) ? $clog2(NumPos) : 1;
  localparam int unsigned DigW   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [PosW-1:0] PosLast = PosW'(NumPos - 1);

  // -------------------------------------------------------------------------
  // Step period
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] presc_last;  // prescaler value on which a tick fires
  logic             presc_rst;   // restart the prescaler this cycle

`ifdef SEG_ROT_SPEED_EN
  logic [1:0]       speed_q;
  logic [CNT_W-1:0] period;

  always_comb begin
    period = CNT_W'(PRESCALE) >> speed;
    // A shift that empties the period would never tick; clamp to one cycle.
    if (period == '0) begin
      presc_last = '0;
    end else begin
      presc_last = period - 1'b1;
    end
    // Restarting on a speed change keeps presc inside the new, shorter period.
    presc_rst = clear | (speed != speed_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      speed_q <= 2'd0;
    end else begin
      speed_q <= speed;
    end
  end
`else
  always_comb begin
    presc_last = CNT_W'(PRESCALE - 1);
    presc_rst  = clear;
  end
`endif

  // -------------------------------------------------------------------------
  // Prescaler
  // -------------------------------------------------------------------------
  logic [CNT_W-1:0] presc_q, presc_d;
  logic             tick;

  always_comb begin
    presc_d = presc_q;
    tick    = 1'b0;
    if (presc_rst) begin
      // clear outranks a tick landing in the same cycle.
      presc_d = '0;
    end else if (run) begin
      if (presc_q == presc_last) begin
        tick    = 1'b1;
        presc_d = '0;
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q <= '0;
    end else begin
      presc_q <= presc_d;
    end
  end

  // -------------------------------------------------------------------------
  // Position counter and wrap pulse
  // -------------------------------------------------------------------------
  logic [PosW-1:0] pos_q, pos_d;
  logic            wrap_q, wrap_d;

  always_comb begin
    pos_d  = pos_q;
    wrap_d = 1'b0;
    if (clear) begin
      pos_d = '0;
    end else if (tick) begin
      if (!dir) begin
        if (pos_q == PosLast) begin
          pos_d  = '0;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q + 1'b1;
        end
      end else begin
        if (pos_q == '0) begin
          pos_d  = PosLast;
          wrap_d = 1'b1;
        end else begin
          pos_d = pos_q - 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pos_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      pos_q  <= pos_d;
      wrap_q <= wrap_d;
    end
  end

  // -------------------------------------------------------------------------
  // Glyph decode (one cycle behind pos)
  // -------------------------------------------------------------------------
  // Positions 0..N-1 run along the top from the leftmost digit (MSB) to the
  // rightmost; positions N..2N-1 run along the bottom from right back to left.
  logic [7:0]            data_q, data_d;
  logic [NUM_DIGITS-1:0] en_q, en_d;

  always_comb begin
    data_d = TOP_PAT;
    en_d   = '1;
    for (int unsigned k = 0; k < NumPos; k++) begin
      if (pos_q == PosW'(k)) begin
        if (k < NUM_DIGITS) begin
          data_d                         = TOP_PAT;
          en_d[DigW'(NUM_DIGITS - 1 - k)] = 1'b0;
        end else begin
          data_d                     = BOT_PAT;
          en_d[DigW'(k - NUM_DIGITS)] = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q <= 8'h00;
      en_q   <= '1;
    end else begin
      data_q <= data_d;
      en_q   <= en_d;
    end
  end

  assign data           = data_q;
  assign display_enable = en_q;
  assign wrap           = wrap_q;

endmodule
